// File: rtl/ap_hs_responder_pkg.sv
// ---------------------------------------------------------------------------
// ap_hs_responder_pkg
// Shared definitions for the ap_ctrl_hs responder and the blocks that drive
// or check it (sequencer, checker).
//   hsState_t        : handshake FSM state encoding
//   DEF_DATA_W       : default width of the core result / ap_out
//   DEF_CNT_W        : default width of the latency counter
//   DEF_TIMEOUT_CYC  : default watchdog limit in cycles
// ---------------------------------------------------------------------------
package ap_hs_responder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2,
      DONE   = 2'd3
   } hsState_t;

   localparam int DEF_DATA_W      = 256;
   localparam int DEF_CNT_W       = 32;
   localparam int DEF_TIMEOUT_CYC = 100000;

endpackage

// File: rtl/ap_hs_responder_if.sv
// ---------------------------------------------------------------------------
// ap_hs_responder_if
// Block-level ap_ctrl_hs handshake bundle between an initiator (sequencer)
// and a responder, plus the result/measurement fields returned on ap_done.
//   ap_start    : initiator request (level)
//   ap_ready    : 1-cycle pulse, request accepted
//   ap_done     : 1-cycle pulse, result fields valid
//   ap_idle     : no operation in progress
//   ap_out      : captured core result (DATA_W)
//   ap_cycles   : launch-to-completion latency (CNT_W)
//   ap_timeout  : last completion was forced by the watchdog
// Modports: master = initiator side, slave = responder side.
// ---------------------------------------------------------------------------
interface ap_hs_responder_if
   import ap_hs_responder_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) ();

   logic              ap_start;
   logic              ap_ready;
   logic              ap_done;
   logic              ap_idle;
   logic [DATA_W-1:0] ap_out;
   logic [CNT_W-1:0]  ap_cycles;
   logic              ap_timeout;

   modport master (
      output ap_start,
      input  ap_ready, ap_done, ap_idle, ap_out, ap_cycles, ap_timeout
   );

   modport slave (
      input  ap_start,
      output ap_ready, ap_done, ap_idle, ap_out, ap_cycles, ap_timeout
   );

endinterface

// File: rtl/ap_hs_responder_sat_counter.sv
// ---------------------------------------------------------------------------
// ap_hs_responder_sat_counter
// Loadable up-counter that sticks at all-ones instead of wrapping, with a
// "reached terminal value" flag. Load has priority over increment.
//   clk, rst_n   : clock, async active-low reset (count cleared)
//   load_i       : load loadVal_i on the next edge
//   loadVal_i    : value to load
//   en_i         : increment on the next edge (ignored while loading)
//   termVal_i    : terminal value for the compare
//   cnt_o        : current count
//   term_o       : count is at or beyond termVal_i
// ---------------------------------------------------------------------------
module ap_hs_responder_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] loadVal_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] termVal_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             term_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: a load restarts the measurement, otherwise count up while
   // enabled but hold at all-ones so a very long wait never reads as short.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = loadVal_i;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register, cleared by reset so a reset mid-operation starts clean.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // ">=" rather than "==" so the flag cannot be skipped past if the counter
   // is ever loaded above the terminal value.
   assign cnt_o  = cnt_q;
   assign term_o = (cnt_q >= termVal_i);

endmodule

// File: rtl/ap_hs_responder.sv
// ---------------------------------------------------------------------------
// ap_hs_responder
// Responder end of the ap_ctrl_hs handshake wrapped around a pulse-start /
// pulse-ready core, with launch-to-completion latency measurement and a
// watchdog that forces completion if the core never answers.
//   clk, rst_n  : clock, async active-low reset
//   apIf        : ap_ctrl_hs bundle (slave side): ap_start in; ap_ready,
//                 ap_done, ap_idle, ap_out, ap_cycles, ap_timeout out
//   core_start  : 1-cycle launch pulse to the core
//   core_ready  : 1-cycle completion pulse from the core
//   core_out    : core result, valid while core_ready is high
// All outputs come straight from registers (state decode or capture regs).
// ---------------------------------------------------------------------------
module ap_hs_responder
   import ap_hs_responder_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              rst_n,
   ap_hs_responder_if.slave  apIf,
   output logic              core_start,
   input  logic              core_ready,
   input  logic [DATA_W-1:0] core_out
);

   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

   hsState_t          state_q;
   hsState_t          state_d;

   logic              cntLoad;
   logic              cntEn;
   logic              cntTerm;
   logic [CNT_W-1:0]  cnt;

   logic              apIdle;
   logic              apReady;
   logic              apDone;

   logic [DATA_W-1:0] apOut_q;
   logic [CNT_W-1:0]  apCycles_q;
   logic              apTimeout_q;

   // State register. Reset drops any operation in flight back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. ap_start is only looked at in IDLE and DONE, so
   // dropping or toggling it mid-operation never aborts anything. DONE goes
   // straight to LAUNCH when the initiator is already asking again.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (apIf.ap_start) state_d = LAUNCH;
         LAUNCH:  state_d = BUSY;
         BUSY:    if (core_ready || cntTerm) state_d = DONE;
         DONE:    state_d = apIf.ap_start ? LAUNCH : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and counter-control decode. The counter is loaded with 1 on the
   // edge into LAUNCH so the launch cycle itself counts as cycle 1.
   always_comb begin
      apIdle     = (state_q == IDLE);
      apReady    = (state_q == LAUNCH);
      core_start = (state_q == LAUNCH);
      apDone     = (state_q == DONE);
      cntLoad    = (state_d == LAUNCH);
      cntEn      = (state_q == LAUNCH) || (state_q == BUSY);
   end

   ap_hs_responder_sat_counter #(
      .CNT_W (CNT_W)
   ) u_latCnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (cntLoad),
      .loadVal_i (CNT_W'(1)),
      .en_i      (cntEn),
      .termVal_i (TIMEOUT_VAL),
      .cnt_o     (cnt),
      .term_o    (cntTerm)
   );

   // Result capture on the way into DONE only. A real core_ready beats a
   // watchdog expiry in the same cycle; on expiry the old result is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         apOut_q     <= '0;
         apCycles_q  <= '0;
         apTimeout_q <= 1'b0;
      end else if (state_q == BUSY) begin
         if (core_ready) begin
            apOut_q     <= core_out;
            apCycles_q  <= cnt;
            apTimeout_q <= 1'b0;
         end else if (cntTerm) begin
            apCycles_q  <= TIMEOUT_VAL;
            apTimeout_q <= 1'b1;
         end
      end
   end

   assign apIf.ap_idle    = apIdle;
   assign apIf.ap_ready   = apReady;
   assign apIf.ap_done    = apDone;
   assign apIf.ap_out     = apOut_q;
   assign apIf.ap_cycles  = apCycles_q;
   assign apIf.ap_timeout = apTimeout_q;

endmodule
